// File: rtl/acq_buffer_pkg.sv
// Shared definitions for the acquisition buffer: readout FSM encodings,
// default sizes and the request clamp helper.
package acq_buffer_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Never send more records than the buffer actually holds.
  function automatic logic [15:0] clamp_count(input logic [15:0] req,
                                              input logic [15:0] avail);
    return (req < avail) ? req : avail;
  endfunction

endpackage

// File: rtl/acq_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port
// with a single cycle of read latency, written so it maps onto block RAM.
module acq_ram #(
  parameter int ADDR_W = 12,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/acq_buffer.sv
// Circular ch1/ch2 sample store that replays the newest records to the host
// over a valid/ready byte link. Define BUFFER_CH2_EN to store and send ch2 too.
module acq_buffer
  import acq_buffer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] ch1_in,
  input  logic [DATA_W-1:0] ch2_in,
  input  logic [15:0]       num_samples,
  input  logic              rd_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

`ifdef BUFFER_CH2_EN
  localparam int REC_W = 2 * DATA_W;
`else
  localparam int REC_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   fill;
  logic [15:0]       remaining;
  logic [15:0]       n;
  logic [REC_W-1:0]  wr_rec;
  logic [REC_W-1:0]  rd_rec;
  logic              write_ok;

`ifdef BUFFER_CH2_EN
  logic [DATA_W-1:0] ch2_hold;
  logic              second_byte;
  assign wr_rec = {ch2_in, ch1_in};
`else
  logic unused_ch2;
  assign unused_ch2 = ^ch2_in;
  assign wr_rec     = ch1_in;
`endif

  // The buffer is frozen for the whole readout, and clear beats a write.
  assign write_ok = wr_en && (state == ST_IDLE) && !clear;
  assign n        = clamp_count(num_samples, 16'(fill));
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  acq_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (REC_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (write_ok),
    .wr_addr (wr_ptr),
    .wr_data (wr_rec),
    .rd_addr (rd_ptr),
    .rd_data (rd_rec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (write_ok) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill != DEPTH)
        fill <= fill + 1'b1;
    end
  end

  // Readout: FETCH presents rd_ptr to the RAM, LOAD captures the registered
  // read data, HOLD keeps the byte stable until the host takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rd_ptr      <= '0;
      remaining   <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
`ifdef BUFFER_CH2_EN
      ch2_hold    <= '0;
      second_byte <= 1'b0;
`endif
    end else if (clear) begin
      state    <= ST_IDLE;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_start) begin
            rd_ptr    <= wr_ptr - n[ADDR_W-1:0];
            remaining <= n;
            state     <= (n == 16'd0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          tx_data     <= rd_rec[DATA_W-1:0];
          tx_valid    <= 1'b1;
          state       <= ST_HOLD;
`ifdef BUFFER_CH2_EN
          ch2_hold    <= rd_rec[REC_W-1:DATA_W];
          second_byte <= 1'b0;
`endif
        end
        ST_HOLD: begin
          if (tx_ready) begin
`ifdef BUFFER_CH2_EN
            if (!second_byte) begin
              tx_data     <= ch2_hold;
              second_byte <= 1'b1;
            end else
`endif
            begin
              tx_valid  <= 1'b0;
              rd_ptr    <= rd_ptr + 1'b1;
              remaining <= remaining - 1'b1;
              state     <= (remaining == 16'd1) ? ST_DONE : ST_FETCH;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_buffer.sv
// Scoreboard bench for acq_buffer: a queue-based history model predicts the
// byte stream of each readout, and a negedge monitor checks every handshake.
`timescale 1ns/1ps
module tb_acq_buffer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_start = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  ch1_in = '0;
  logic [7:0]  ch2_in = '0;
  logic [15:0] num_samples = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  acq_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .wr_en       (wr_en),
    .ch1_in      (ch1_in),
    .ch2_in      (ch2_in),
    .num_samples (num_samples),
    .rd_start    (rd_start),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [15:0] hist[$];
  logic [7:0]  exp_q[$];
  bit done_pending = 1'b0;
  int accepted = 0;
  int dones_seen = 0;
  int dones_expected = 0;
  bit random_ready = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Host side: either always ready or a coin flip every cycle.
  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic       prev_stall = 1'b0;
  logic       prev_clear = 1'b0;
  logic [7:0] prev_data = '0;

  initial forever begin
    @(negedge clk);
    if (prev_stall && !prev_clear && !reset) begin
      check_output("stall_valid_held", tx_valid, 1);
      check_output("stall_data_held", tx_data, prev_data);
    end
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_byte: got %0h, expected no byte at %0t", tx_data, $time);
      end else begin
        check_output("tx_byte", tx_data, exp_q.pop_front());
      end
      accepted++;
    end
    if (done) begin
      check_output("done_expected", done_pending, 1);
      check_output("bytes_left_at_done", exp_q.size(), 0);
      done_pending = 1'b0;
      dones_seen++;
    end
    prev_stall = tx_valid && !tx_ready;
    prev_clear = clear || reset;
    prev_data  = tx_data;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_flush();
    hist.delete();
    exp_q.delete();
    done_pending = 1'b0;
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_flush();
  endtask

  task automatic write_records(input int count, input bit seq, input int base);
    for (int i = 0; i < count; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = seq ? 8'(base + i) : 8'($urandom);
      b = seq ? 8'(8'h80 + base + i) : 8'($urandom);
      @(posedge clk);
      #1;
      wr_en  = 1'b1;
      ch1_in = a;
      ch2_in = b;
      hist.push_back({b, a});
      if (hist.size() > DEPTH)
        hist.delete(0);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Newest min(num, fill) records, oldest first.
  task automatic start_read(input int num);
    int n;
    n = (num < hist.size()) ? num : hist.size();
    for (int k = hist.size() - n; k < hist.size(); k++) begin
      exp_q.push_back(hist[k][7:0]);
`ifdef BUFFER_CH2_EN
      exp_q.push_back(hist[k][15:8]);
`endif
    end
    done_pending = 1'b1;
    @(posedge clk);
    #1;
    num_samples = 16'(num);
    rd_start = 1'b1;
    @(posedge clk);
    #1;
    rd_start = 1'b0;
  endtask

  task automatic apply_stimulus(input int num, input bit wr_noise, output int cycles);
    start_read(num);
    dones_expected++;
    cycles = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        wr_en = 1'b0;
        break;
      end
      if (t == 2999) begin
        checks++;
        errors++;
        $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", cycles);
      end
      if (wr_noise) begin
        wr_en  = 1'($urandom_range(0, 1));
        ch1_in = 8'($urandom);
        ch2_in = 8'($urandom);
      end
    end
    wr_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int acc0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_tx_valid", tx_valid, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_tx_data", tx_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_flush();

    $display("[TB] basic readout of the last 4 of 10 records");
    write_records(10, 1'b1, 0);
    apply_stimulus(4, 1'b0, cyc);

    $display("[TB] wrap across the top address");
    do_clear();
    write_records(20, 1'b1, 0);
    apply_stimulus(16, 1'b0, cyc);

    $display("[TB] zero-length and over-long requests");
    do_clear();
    write_records(5, 1'b1, 32);
    apply_stimulus(100, 1'b0, cyc);
    apply_stimulus(0, 1'b0, cyc);
    check_output("zero_req_done_latency", cyc, 1);

    $display("[TB] random backpressure with random contents");
    random_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      write_records(int'($urandom_range(1, 12)), 1'b0, 0);
      apply_stimulus(int'($urandom_range(0, 20)), 1'b0, cyc);
    end

    $display("[TB] writes during readout are dropped");
    write_records(16, 1'b0, 0);
    apply_stimulus(7, 1'b1, cyc);
    apply_stimulus(16, 1'b0, cyc);
    random_ready = 1'b0;

    $display("[TB] clear after two accepted bytes");
    do_clear();
    write_records(8, 1'b1, 64);
    acc0 = accepted;
    start_read(5);
    for (int t = 0; t < 200 && accepted < acc0 + 2; t++)
      @(posedge clk);
    check_output("two_bytes_accepted", accepted - acc0, 2);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_flush();
    @(negedge clk);
    check_output("clear_tx_valid", tx_valid, 0);
    check_output("clear_busy", busy, 0);
    check_output("clear_done", done, 0);
    repeat (4) @(posedge clk);
    #1;
    apply_stimulus(4, 1'b0, cyc);
    check_output("post_clear_done_latency", cyc, 1);

    $display("[TB] asynchronous reset mid-readout");
    write_records(6, 1'b1, 100);
    start_read(6);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_output("areset_tx_valid", tx_valid, 0);
    check_output("areset_busy", busy, 0);
    check_output("areset_done", done, 0);
    check_output("areset_tx_data", tx_data, 0);
    model_flush();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    apply_stimulus(3, 1'b0, cyc);
    check_output("post_reset_done_latency", cyc, 1);

    repeat (3) @(posedge clk);
    check_output("done_pulse_count", dones_seen, dones_expected);
    check_output("no_bytes_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
